// File: rtl/int_stim_gen_if.sv
// Bus bundle between the interrupt stimulus generator and the bench/CPU side.
// It carries the CPU observation signals (PC and store port), the trigger-table
// configuration port, and the generator's outputs, including a debug copy of
// the FSM state.
// The master drives the CPU and configuration signals; the slave (the
// generator) drives the interrupt and status signals.
// There is no valid/ready handshake here. Every input is sampled on each
// rising clock edge. cfg_we is a one-cycle write strobe that is qualified
// only by itself, and m_int_byteen != 0 marks a store in that cycle.
interface int_stim_gen_if #(
    parameter int NUM_TRIG = 4
);
    localparam int IW = (NUM_TRIG > 1) ? $clog2(NUM_TRIG) : 1;

    logic [31:0]   macroscopic_pc;
    logic [31:0]   m_int_addr;
    logic [3:0]    m_int_byteen;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [31:0]   cfg_pc;
    logic [7:0]    cfg_count;
    logic          cfg_mode;
    logic          interrupt;
    logic [IW-1:0] int_src;
    logic [15:0]   fire_total;
    logic          busy;
    logic          timeout_flag;
    logic [1:0]    state_dbg;

    modport master (
        output macroscopic_pc, m_int_addr, m_int_byteen,
        output cfg_we, cfg_idx, cfg_pc, cfg_count, cfg_mode,
        input  interrupt, int_src, fire_total, busy, timeout_flag, state_dbg
    );

    modport slave (
        input  macroscopic_pc, m_int_addr, m_int_byteen,
        input  cfg_we, cfg_idx, cfg_pc, cfg_count, cfg_mode,
        output interrupt, int_src, fire_total, busy, timeout_flag, state_dbg
    );
endinterface

// File: rtl/int_stim_gen.sv
// int_stim_gen: PC-triggered interrupt injector for the MIPS bench.
// A small trigger table is compared against the CPU's macroscopic PC. On a
// match, the generator raises `interrupt`. In level mode the line stays high
// until a store to ACK_ADDR acknowledges it. In pulse mode it is high for
// exactly one cycle. A cooldown state then waits for the PC to move, so a
// stalled instruction cannot re-fire.
// Optional feature macro: INT_STIM_TIMEOUT_EN. When it is defined, an
// unacknowledged level interrupt is dropped after HOLD_MAX cycles and the
// sticky timeout_flag is set.
module int_stim_gen #(
    parameter int          NUM_TRIG = 4,
    parameter logic [31:0] ACK_ADDR = 32'h0000_7f20,
    parameter int          HOLD_MAX = 64
) (
    input  logic           clk,
    input  logic           reset,
    int_stim_gen_if.slave  bus
);
    localparam int IW = (NUM_TRIG > 1) ? $clog2(NUM_TRIG) : 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ASSERT   = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_t;

    // Trigger table; a count of zero disables the entry.
    logic [29:0] trig_pc    [NUM_TRIG];
    logic [7:0]  trig_count [NUM_TRIG];
    logic        trig_mode  [NUM_TRIG];

    state_t        state_q, state_next;
    logic [IW-1:0] int_src_q, int_src_next;
    logic [29:0]   fire_pc_q, fire_pc_next;
    logic          mode_q, mode_next;
    logic [15:0]   total_q, total_next;

    logic [29:0]         pc_word;
    logic                ack;
    logic [NUM_TRIG-1:0] cfg_sel;
    logic [NUM_TRIG-1:0] match;
    logic                win_any;
    logic [IW-1:0]       win_idx;
    logic                win_mode;
    logic                fire;

    assign pc_word = bus.macroscopic_pc[31:2];

    // Ack is any store whose word address equals ACK_ADDR; byte offset ignored.
    assign ack = (bus.m_int_byteen != 4'b0000) &&
                 (bus.m_int_addr[31:2] == ACK_ADDR[31:2]);

    // Decode the config write target; an out-of-range index selects nothing.
    always_comb begin
        cfg_sel = '0;
        for (int i = 0; i < NUM_TRIG; i++) begin
            cfg_sel[i] = bus.cfg_we && (bus.cfg_idx == IW'(i));
        end
    end

    // Per-entry match. An entry being rewritten this cycle is masked, so the
    // write wins and the next-lower-priority entry may still fire.
    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_TRIG; i++) begin
            match[i] = (trig_count[i] != 8'd0) &&
                       (trig_pc[i] == pc_word) &&
                       !cfg_sel[i];
        end
    end

    // Priority pick: the lowest matching index wins.
    always_comb begin
        win_any  = 1'b0;
        win_idx  = '0;
        win_mode = 1'b0;
        for (int i = NUM_TRIG - 1; i >= 0; i--) begin
            if (match[i]) begin
                win_any  = 1'b1;
                win_idx  = IW'(i);
                win_mode = trig_mode[i];
            end
        end
    end

`ifdef INT_STIM_TIMEOUT_EN
    localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX + 1) : 1;

    logic [HW-1:0] hold_q, hold_next;
    logic          timeout_q, timeout_next;
`endif

    // Next-state and next-output logic for the IDLE/ASSERT/COOLDOWN FSM.
    always_comb begin
        state_next   = state_q;
        int_src_next = int_src_q;
        fire_pc_next = fire_pc_q;
        mode_next    = mode_q;
        total_next   = total_q;
        fire         = 1'b0;
`ifdef INT_STIM_TIMEOUT_EN
        hold_next    = hold_q;
        timeout_next = timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_any) begin
                    fire         = 1'b1;
                    state_next   = ST_ASSERT;
                    int_src_next = win_idx;
                    fire_pc_next = pc_word;
                    mode_next    = win_mode;
                    if (total_q != 16'hffff) begin
                        total_next = total_q + 16'd1;
                    end
`ifdef INT_STIM_TIMEOUT_EN
                    hold_next = '0;
`endif
                end
            end
            ST_ASSERT: begin
                if (mode_q) begin
                    // Pulse mode: always exactly one cycle, ack is irrelevant.
                    state_next = ST_COOLDOWN;
                end else if (ack) begin
                    // A normal ack wins over a simultaneous timeout.
                    state_next = ST_COOLDOWN;
                end
`ifdef INT_STIM_TIMEOUT_EN
                else if (hold_q == HW'(HOLD_MAX - 1)) begin
                    state_next   = ST_COOLDOWN;
                    timeout_next = 1'b1;
                end else begin
                    hold_next = hold_q + HW'(1);
                end
`endif
            end
            ST_COOLDOWN: begin
                // Re-arm only once the PC has left the instruction that fired.
                if (pc_word != fire_pc_q) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state and latched firing context.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            int_src_q <= '0;
            fire_pc_q <= '0;
            mode_q    <= 1'b0;
            total_q   <= '0;
        end else begin
            state_q   <= state_next;
            int_src_q <= int_src_next;
            fire_pc_q <= fire_pc_next;
            mode_q    <= mode_next;
            total_q   <= total_next;
        end
    end

`ifdef INT_STIM_TIMEOUT_EN
    // Level-hold cycle counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_next;
            timeout_q <= timeout_next;
        end
    end

    assign bus.timeout_flag = timeout_q;
`else
    assign bus.timeout_flag = 1'b0;
`endif

    // Trigger table: config writes, and the decrement of the entry that fired.
    // A fired entry had a nonzero count, so the decrement never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_TRIG; i++) begin
                trig_pc[i]    <= '0;
                trig_count[i] <= '0;
                trig_mode[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_TRIG; i++) begin
                if (cfg_sel[i]) begin
                    trig_pc[i]    <= bus.cfg_pc[31:2];
                    trig_count[i] <= bus.cfg_count;
                    trig_mode[i]  <= bus.cfg_mode;
                end else if (fire && (win_idx == IW'(i))) begin
                    trig_count[i] <= trig_count[i] - 8'd1;
                end
            end
        end
    end

    // Interrupt is high exactly while in ASSERT, which is a registered state.
    assign bus.interrupt  = (state_q == ST_ASSERT);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.int_src    = int_src_q;
    assign bus.fire_total = total_q;
    assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_int_stim_gen.sv
// Testbench for int_stim_gen. A directed vector table covers the per-cycle
// behaviour. Hand-written sequences cover the hold/timeout behaviour, a
// count of 255, and reset during ASSERT. A queue-based scoreboard checks
// int_src on every rising edge of interrupt.
module tb_int_stim_gen;
    logic clk = 1'b0;
    logic reset = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    int_stim_gen_if #(.NUM_TRIG(4)) bus ();

    int_stim_gen #(
        .NUM_TRIG (4),
        .ACK_ADDR (32'h0000_7f20),
        .HOLD_MAX (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock and reset block
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  idx;
        logic [31:0] cpc;
        logic [7:0]  cnt;
        logic        mode;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        e_int;
        logic [1:0]  e_src;
        logic [15:0] e_tot;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];
    logic [1:0] exp_q[$];

    // Scoreboard: each rising edge of interrupt must match the next expected source.
    logic prev_int = 1'b0;
    always @(negedge clk) begin
        if (bus.interrupt && !prev_int) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_fire: unexpected fire, int_src=%0d, none expected", bus.int_src);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                n_cmp++;
                if (bus.int_src !== e) begin
                    n_err++;
                    $display("FAIL sb_src: got %0d expected %0d", bus.int_src, e);
                end
            end
        end
        prev_int <= bus.interrupt;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [1:0] idx, input logic [31:0] cpc,
                         input logic [7:0] cnt, input logic mode, input logic [31:0] pc,
                         input logic [31:0] addr, input logic [3:0] be);
        bus.cfg_we         = we;
        bus.cfg_idx        = idx;
        bus.cfg_pc         = cpc;
        bus.cfg_count      = cnt;
        bus.cfg_mode       = mode;
        bus.macroscopic_pc = pc;
        bus.m_int_addr     = addr;
        bus.m_int_byteen   = be;
    endtask

    task automatic add(input logic we, input logic [1:0] idx, input logic [31:0] cpc,
                       input logic [7:0] cnt, input logic mode, input logic [31:0] pc,
                       input logic [31:0] addr, input logic [3:0] be, input logic e_int,
                       input logic [1:0] e_src, input logic [15:0] e_tot, input logic e_busy);
        vec_t v;
        v.we = we; v.idx = idx; v.cpc = cpc; v.cnt = cnt; v.mode = mode;
        v.pc = pc; v.addr = addr; v.be = be;
        v.e_int = e_int; v.e_src = e_src; v.e_tot = e_tot; v.e_busy = e_busy;
        vecs.push_back(v);
    endtask

    // Plain CPU cycle: no config write, no store.
    task automatic add_pc(input logic [31:0] pc, input logic e_int, input logic [1:0] e_src,
                          input logic [15:0] e_tot, input logic e_busy);
        add(1'b0, 2'd0, 32'h0, 8'd0, 1'b0, pc, 32'h0, 4'h0, e_int, e_src, e_tot, e_busy);
    endtask

    task automatic add_st(input logic [31:0] pc, input logic [31:0] addr, input logic [3:0] be,
                          input logic e_int, input logic [1:0] e_src, input logic [15:0] e_tot,
                          input logic e_busy);
        add(1'b0, 2'd0, 32'h0, 8'd0, 1'b0, pc, addr, be, e_int, e_src, e_tot, e_busy);
    endtask

    task automatic add_cfg(input logic [1:0] idx, input logic [31:0] cpc, input logic [7:0] cnt,
                           input logic mode, input logic [31:0] pc, input logic e_int,
                           input logic [1:0] e_src, input logic [15:0] e_tot, input logic e_busy);
        add(1'b1, idx, cpc, cnt, mode, pc, 32'h0, 4'h0, e_int, e_src, e_tot, e_busy);
    endtask

    initial begin
        logic       prev_e;
        int         hi;
        int         fires;
        logic [15:0] exp_tot;

        drive(1'b0, 2'd0, 32'h0, 8'd0, 1'b0, 32'h1000, 32'h0, 4'h0);
        reset = 1'b1;
        step();
        step();
        chk("rst_interrupt", {31'b0, bus.interrupt}, 32'd0);
        chk("rst_int_src", {30'b0, bus.int_src}, 32'd0);
        chk("rst_fire_total", {16'b0, bus.fire_total}, 32'd0);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_timeout", {31'b0, bus.timeout_flag}, 32'd0);
        reset = 1'b0;

        // Level entry 0, acks with wrong address and zero byteen, then a real ack
        add_cfg(2'd0, 32'h3010, 8'd1, 1'b0, 32'h1000, 0, 0, 0, 0);
        add_pc(32'h3010, 1, 0, 1, 1);
        add_st(32'h3010, 32'h7f24, 4'hf, 1, 0, 1, 1);
        add_st(32'h3014, 32'h7f20, 4'h0, 1, 0, 1, 1);
        add_st(32'h3014, 32'h7f20, 4'hf, 0, 0, 1, 1);
        add_pc(32'h3014, 0, 0, 1, 0);
        add_pc(32'h3010, 0, 0, 1, 0);
        // Entries 1 and 3 share a PC; entry1 wins and only its count drops
        add_cfg(2'd1, 32'h3020, 8'd1, 1'b0, 32'h1000, 0, 0, 1, 0);
        add_cfg(2'd3, 32'h3020, 8'd1, 1'b0, 32'h1000, 0, 0, 1, 0);
        add_pc(32'h3022, 1, 1, 2, 1);
        add_st(32'h3024, 32'h7f22, 4'b0100, 0, 1, 2, 1);
        add_pc(32'h3024, 0, 1, 2, 0);
        add_pc(32'h3020, 1, 3, 3, 1);
        add_st(32'h3020, 32'h7f20, 4'hf, 0, 3, 3, 1);
        add_pc(32'h3020, 0, 3, 3, 1);
        add_pc(32'h3028, 0, 3, 3, 0);
        // Pulse entry 2, count 2, PC stalls on the target
        add_cfg(2'd2, 32'h3030, 8'd2, 1'b1, 32'h1000, 0, 3, 3, 0);
        add_pc(32'h3030, 1, 2, 4, 1);
        add_pc(32'h3030, 0, 2, 4, 1);
        add_pc(32'h3030, 0, 2, 4, 1);
        add_st(32'h3030, 32'h7f20, 4'hf, 0, 2, 4, 1);
        add_pc(32'h3030, 0, 2, 4, 1);
        add_pc(32'h3034, 0, 2, 4, 0);
        add_pc(32'h3030, 1, 2, 5, 1);
        add_st(32'h3030, 32'h7f20, 4'hf, 0, 2, 5, 1);
        add_pc(32'h3034, 0, 2, 5, 0);
        add_pc(32'h3030, 0, 2, 5, 0);
        // Config write in the match cycle wins; a lower-priority entry may still fire
        add_cfg(2'd0, 32'h3040, 8'd1, 1'b0, 32'h1000, 0, 2, 5, 0);
        add_cfg(2'd0, 32'h3040, 8'd0, 1'b0, 32'h3040, 0, 2, 5, 0);
        add_pc(32'h3040, 0, 2, 5, 0);
        add_cfg(2'd0, 32'h3050, 8'd1, 1'b0, 32'h1000, 0, 2, 5, 0);
        add_cfg(2'd2, 32'h3050, 8'd1, 1'b1, 32'h1000, 0, 2, 5, 0);
        add_cfg(2'd0, 32'h3050, 8'd2, 1'b0, 32'h3050, 1, 2, 6, 1);
        add_pc(32'h3050, 0, 2, 6, 1);
        add_pc(32'h3054, 0, 2, 6, 0);
        // A config write during ASSERT leaves the FSM alone
        add_pc(32'h3050, 1, 0, 7, 1);
        add_cfg(2'd1, 32'h3060, 8'd1, 1'b1, 32'h3050, 1, 0, 7, 1);
        add_st(32'h3050, 32'h7f20, 4'h1, 0, 0, 7, 1);
        add_pc(32'h3058, 0, 0, 7, 0);

        prev_e = 1'b0;
        foreach (vecs[n]) begin
            vec_t v;
            v = vecs[n];
            drive(v.we, v.idx, v.cpc, v.cnt, v.mode, v.pc, v.addr, v.be);
            if (v.e_int && !prev_e) exp_q.push_back(v.e_src);
            prev_e = v.e_int;
            step();
            chk($sformatf("v%0d_interrupt", n), {31'b0, bus.interrupt}, {31'b0, v.e_int});
            chk($sformatf("v%0d_int_src", n), {30'b0, bus.int_src}, {30'b0, v.e_src});
            chk($sformatf("v%0d_fire_total", n), {16'b0, bus.fire_total}, {16'b0, v.e_tot});
            chk($sformatf("v%0d_busy", n), {31'b0, bus.busy}, {31'b0, v.e_busy});
        end
        exp_tot = 16'd7;

        // Level hold without ack
        drive(1'b1, 2'd1, 32'h3070, 8'd1, 1'b0, 32'h1000, 32'h0, 4'h0);
        step();
        drive(1'b0, 2'd0, 32'h0, 8'd0, 1'b0, 32'h3070, 32'h0, 4'h0);
        exp_q.push_back(2'd1);
        step();
        exp_tot++;
        chk("hold_fire", {31'b0, bus.interrupt}, 32'd1);
        hi = 1;
`ifdef INT_STIM_TIMEOUT_EN
        for (int k = 0; k < 30 && bus.interrupt; k++) begin
            step();
            if (bus.interrupt) hi++;
        end
        chk("timeout_high_cycles", hi, 32'd8);
        chk("timeout_flag_set", {31'b0, bus.timeout_flag}, 32'd1);
        chk("timeout_busy", {31'b0, bus.busy}, 32'd1);
`else
        for (int k = 0; k < 20; k++) begin
            step();
            if (bus.interrupt) hi++;
        end
        chk("hold_high_cycles", hi, 32'd21);
        chk("hold_no_timeout", {31'b0, bus.timeout_flag}, 32'd0);
        bus.m_int_addr   = 32'h7f20;
        bus.m_int_byteen = 4'hf;
        step();
        bus.m_int_byteen = 4'h0;
        chk("hold_ack_release", {31'b0, bus.interrupt}, 32'd0);
`endif
        bus.macroscopic_pc = 32'h3074;
        step();
        chk("hold_back_idle", {31'b0, bus.busy}, 32'd0);
`ifdef INT_STIM_TIMEOUT_EN
        chk("timeout_sticky", {31'b0, bus.timeout_flag}, 32'd1);
`else
        chk("timeout_tied", {31'b0, bus.timeout_flag}, 32'd0);
`endif

        // Count of 255 gives exactly 255 fires, never wrapping
        drive(1'b1, 2'd3, 32'h3100, 8'd255, 1'b1, 32'h1000, 32'h0, 4'h0);
        step();
        bus.cfg_we = 1'b0;
        fires = 0;
        for (int v = 0; v < 260; v++) begin
            bus.macroscopic_pc = 32'h3100;
            if (v < 255) exp_q.push_back(2'd3);
            step();
            if (bus.interrupt) fires++;
            step();
            bus.macroscopic_pc = 32'h3104;
            step();
        end
        exp_tot = exp_tot + 16'd255;
        chk("cnt255_fires", fires, 32'd255);
        chk("cnt255_total", {16'b0, bus.fire_total}, {16'b0, exp_tot});

        // Reset in the middle of ASSERT
        drive(1'b1, 2'd0, 32'h3200, 8'd1, 1'b0, 32'h1000, 32'h0, 4'h0);
        step();
        bus.cfg_we = 1'b0;
        bus.macroscopic_pc = 32'h3200;
        exp_q.push_back(2'd0);
        step();
        chk("rstmid_fired", {31'b0, bus.interrupt}, 32'd1);
        reset = 1'b1;
        step();
        chk("rstmid_interrupt", {31'b0, bus.interrupt}, 32'd0);
        chk("rstmid_total", {16'b0, bus.fire_total}, 32'd0);
        chk("rstmid_busy", {31'b0, bus.busy}, 32'd0);
        chk("rstmid_src", {30'b0, bus.int_src}, 32'd0);
        chk("rstmid_timeout", {31'b0, bus.timeout_flag}, 32'd0);
        reset = 1'b0;
        step();
        chk("rstmid_table_clear", {31'b0, bus.interrupt}, 32'd0);
        step();
        chk("rstmid_table_clear2", {31'b0, bus.busy}, 32'd0);

        chk("sb_queue_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
